// File: rtl/display_seq_pkg.sv
// Shared types and constants for the display word sequencer: FSM states,
// snapshot geometry and the word-index wrap helper.
package display_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_PAUSED = 2'd2
  } seq_state_e;

  localparam int NUM_WORDS = 9;
  localparam int IDX_W     = 4;

  localparam logic [IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_LAST) ? IDX_FIRST : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/display_word_sequencer_button_debounce.sv
// Raw button conditioner: 2-flop synchronizer, consecutive-stable-cycle
// debouncer and a one-cycle registered pulse on each debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1048576
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the run.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/display_word_sequencer.sv
// Captures a nonce+hash snapshot and pages its nine 32-bit words onto the
// display bus. Optional macro DISPLAY_SEQ_WORD_ID_EN puts the index in [31:28].
module display_word_sequencer #(
  parameter int DWELL_CYCLES    = 134217728,
  parameter int DEBOUNCE_CYCLES = 1048576
) (
  input  logic         clk_in,
  input  logic         reset_n_in,
  input  logic         load_valid_in,
  output logic         load_ready_out,
  input  logic [31:0]  nonce_in,
  input  logic [255:0] hash_in,
  input  logic         btn_next_in,
  input  logic         btn_hold_in,
  output logic [31:0]  Word_out,
  output logic [3:0]   word_idx_out,
  output logic         paused_out
);

  import display_seq_pkg::*;

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    dwell_q;
  logic [31:0]      words_q [NUM_WORDS];
  logic [31:0]      word_q;
  logic [IDX_W-1:0] widx_q;
  logic             ready_q;
  logic             paused_q;

  logic        next_rise, hold_rise;
  logic        xfer, active, dwell_hit, advance;
  logic [31:0] word_sel, word_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk_i (clk_in),
    .rst_ni(reset_n_in),
    .btn_i (btn_next_in),
    .rise_o(next_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
    .clk_i (clk_in),
    .rst_ni(reset_n_in),
    .btn_i (btn_hold_in),
    .rise_o(hold_rise)
  );

  assign xfer      = load_valid_in & ready_q;
  assign active    = (state_q != ST_IDLE);
  assign dwell_hit = (state_q == ST_AUTO) && (dwell_q == DWELL_MAX);
  // Dwell expiry and a next press in one cycle still move by one word.
  assign advance   = active & (next_rise | dwell_hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer)      state_d = ST_AUTO;
      ST_AUTO:   if (hold_rise) state_d = ST_PAUSED;
      ST_PAUSED: if (hold_rise) state_d = ST_AUTO;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_sel = '0;
    if (idx_q <= IDX_LAST) word_sel = words_q[idx_q];
  end

`ifdef DISPLAY_SEQ_WORD_ID_EN
  assign word_d = {idx_q, word_sel[27:0]};
`else
  assign word_d = word_sel;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_FIRST;
      dwell_q  <= '0;
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
      word_q   <= '0;
      widx_q   <= '0;
      ready_q  <= 1'b1;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d != ST_PAUSED);
      paused_q <= (state_d == ST_PAUSED);
      word_q   <= word_d;
      widx_q   <= idx_q;
      // A capture overrides any same-cycle advance: the new snapshot starts at word 0.
      if (xfer) begin
        words_q[0] <= nonce_in;
        for (int i = 1; i < NUM_WORDS; i++)
          words_q[i] <= hash_in[32*(NUM_WORDS-i)-1 -: 32];
        idx_q   <= IDX_FIRST;
        dwell_q <= '0;
      end else if (advance) begin
        idx_q   <= idx_inc(idx_q);
        dwell_q <= '0;
      end else if (hold_rise && active) begin
        dwell_q <= '0;
      end else if (state_q == ST_AUTO) begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  assign load_ready_out = ready_q;
  assign Word_out       = word_q;
  assign word_idx_out   = widx_q;
  assign paused_out     = paused_q;

endmodule

// File: tb/tb_display_word_sequencer.sv
// Directed bench for display_word_sequencer with DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
module tb_display_word_sequencer;

`ifdef DISPLAY_SEQ_WORD_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  localparam logic [255:0] HASH = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

  logic         clk_in = 1'b0;
  logic         reset_n_in;
  logic         load_valid_in;
  logic         load_ready_out;
  logic [31:0]  nonce_in;
  logic [255:0] hash_in;
  logic         btn_next_in;
  logic         btn_hold_in;
  logic [31:0]  Word_out;
  logic [3:0]   word_idx_out;
  logic         paused_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  display_word_sequencer #(.DWELL_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .load_valid_in (load_valid_in),
    .load_ready_out(load_ready_out),
    .nonce_in      (nonce_in),
    .hash_in       (hash_in),
    .btn_next_in   (btn_next_in),
    .btn_hold_in   (btn_hold_in),
    .Word_out      (Word_out),
    .word_idx_out  (word_idx_out),
    .paused_out    (paused_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] exp_word(input logic [3:0] idx, input logic [31:0] w);
    return ID_EN ? {idx, w[27:0]} : w;
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    reset_n_in = 1'b0; load_valid_in = 1'b0; btn_next_in = 1'b0; btn_hold_in = 1'b0;
    nonce_in = '0; hash_in = '0;
    tick; tick;
    chk_cnt++; if (Word_out !== 32'h0) $display("FAIL rst_word: got %h want 0", Word_out); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL rst_idx: got %0d want 0", word_idx_out); else pass_cnt++;
    chk_cnt++; if (paused_out !== 1'b0) $display("FAIL rst_paused: got %b want 0", paused_out); else pass_cnt++;
    chk_cnt++; if (load_ready_out !== 1'b1) $display("FAIL rst_ready: got %b want 1", load_ready_out); else pass_cnt++;
    reset_n_in = 1'b1;
    tick;
  endtask

  task automatic test_load_auto;
    nonce_in = 32'hDEADBEEF; hash_in = HASH; load_valid_in = 1'b1;
    tick;
    load_valid_in = 1'b0;
    tick;
    chk_cnt++; if (Word_out !== exp_word(4'd0, 32'hDEADBEEF)) $display("FAIL hs_latency: got %h want %h", Word_out, exp_word(4'd0, 32'hDEADBEEF)); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL hs_idx: got %0d want 0", word_idx_out); else pass_cnt++;
    repeat (7) tick;
    chk_cnt++; if (Word_out !== exp_word(4'd0, 32'hDEADBEEF)) $display("FAIL dwell_early: got %h want %h", Word_out, exp_word(4'd0, 32'hDEADBEEF)); else pass_cnt++;
    tick;
    chk_cnt++; if (Word_out !== exp_word(4'd1, 32'h11111111)) $display("FAIL dwell_word1: got %h want %h", Word_out, exp_word(4'd1, 32'h11111111)); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd1) $display("FAIL dwell_idx1: got %0d want 1", word_idx_out); else pass_cnt++;
    repeat (56) tick;
    chk_cnt++; if (word_idx_out !== 4'd8) $display("FAIL idx8: got %0d want 8", word_idx_out); else pass_cnt++;
    chk_cnt++; if (Word_out !== exp_word(4'd8, 32'h88888888)) $display("FAIL word8: got %h want %h", Word_out, exp_word(4'd8, 32'h88888888)); else pass_cnt++;
    repeat (8) tick;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL wrap_idx: got %0d want 0", word_idx_out); else pass_cnt++;
    chk_cnt++; if (Word_out !== exp_word(4'd0, 32'hDEADBEEF)) $display("FAIL wrap_word: got %h want %h", Word_out, exp_word(4'd0, 32'hDEADBEEF)); else pass_cnt++;
  endtask

  task automatic test_hold_pause;
    logic bad;
    tick;
    btn_hold_in = 1'b1;
    repeat (7) tick;
    chk_cnt++; if (paused_out !== 1'b1) $display("FAIL pause_flag: got %b want 1", paused_out); else pass_cnt++;
    chk_cnt++; if (load_ready_out !== 1'b0) $display("FAIL pause_ready: got %b want 0", load_ready_out); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd1) $display("FAIL pause_idx: got %0d want 1", word_idx_out); else pass_cnt++;
    btn_hold_in = 1'b0;
    nonce_in = 32'hCAFEF00D; load_valid_in = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      tick;
      if (word_idx_out !== 4'd1 || load_ready_out !== 1'b0 || paused_out !== 1'b1) bad = 1'b1;
    end
    chk_cnt++; if (bad !== 1'b0) $display("FAIL pause_stable: got unstable=%b want 0", bad); else pass_cnt++;
    chk_cnt++; if (Word_out !== exp_word(4'd1, 32'h11111111)) $display("FAIL pause_word: got %h want %h", Word_out, exp_word(4'd1, 32'h11111111)); else pass_cnt++;
  endtask

  task automatic test_next_bounce;
    btn_next_in = 1'b1; tick;
    btn_next_in = 1'b0; tick;
    btn_next_in = 1'b1;
    repeat (7) tick;
    chk_cnt++; if (word_idx_out !== 4'd1) $display("FAIL next_early: got %0d want 1", word_idx_out); else pass_cnt++;
    tick;
    chk_cnt++; if (word_idx_out !== 4'd2) $display("FAIL next_latency: got %0d want 2", word_idx_out); else pass_cnt++;
    chk_cnt++; if (Word_out !== exp_word(4'd2, 32'h22222222)) $display("FAIL next_word: got %h want %h", Word_out, exp_word(4'd2, 32'h22222222)); else pass_cnt++;
    repeat (2) tick;
    btn_next_in = 1'b0;
    repeat (12) tick;
    chk_cnt++; if (word_idx_out !== 4'd2) $display("FAIL next_single: got %0d want 2", word_idx_out); else pass_cnt++;
  endtask

  task automatic test_hold_resume;
    btn_hold_in = 1'b1;
    repeat (7) tick;
    chk_cnt++; if (paused_out !== 1'b0) $display("FAIL resume_flag: got %b want 0", paused_out); else pass_cnt++;
    chk_cnt++; if (load_ready_out !== 1'b1) $display("FAIL resume_ready: got %b want 1", load_ready_out); else pass_cnt++;
    tick;
    btn_hold_in = 1'b0; load_valid_in = 1'b0;
    tick;
    chk_cnt++; if (Word_out !== exp_word(4'd0, 32'hCAFEF00D)) $display("FAIL pending_load: got %h want %h", Word_out, exp_word(4'd0, 32'hCAFEF00D)); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL pending_idx: got %0d want 0", word_idx_out); else pass_cnt++;
  endtask

  task automatic test_simul_dwell_next;
    nonce_in = 32'hDEADBEEF; load_valid_in = 1'b1;
    tick;
    load_valid_in = 1'b0;
    repeat (25) tick;
    btn_next_in = 1'b1;
    repeat (7) tick;
    chk_cnt++; if (word_idx_out !== 4'd3) $display("FAIL simul_pre: got %0d want 3", word_idx_out); else pass_cnt++;
    tick;
    chk_cnt++; if (word_idx_out !== 4'd4) $display("FAIL simul_idx: got %0d want 4", word_idx_out); else pass_cnt++;
    chk_cnt++; if (Word_out !== exp_word(4'd4, 32'h44444444)) $display("FAIL simul_word: got %h want %h", Word_out, exp_word(4'd4, 32'h44444444)); else pass_cnt++;
    btn_next_in = 1'b0;
    repeat (7) tick;
    chk_cnt++; if (word_idx_out !== 4'd4) $display("FAIL simul_dwell_clr: got %0d want 4", word_idx_out); else pass_cnt++;
    tick;
    chk_cnt++; if (word_idx_out !== 4'd5) $display("FAIL simul_next_dwell: got %0d want 5", word_idx_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    nonce_in = 32'hDEADBEEF; load_valid_in = 1'b1;
    tick;
    load_valid_in = 1'b0;
    repeat (46) tick;
    btn_next_in = 1'b1;
    repeat (3) tick;
    chk_cnt++; if (word_idx_out !== 4'd6) $display("FAIL mid_idx6: got %0d want 6", word_idx_out); else pass_cnt++;
    reset_n_in = 1'b0;
    tick;
    chk_cnt++; if (Word_out !== 32'h0) $display("FAIL mid_rst_word: got %h want 0", Word_out); else pass_cnt++;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL mid_rst_idx: got %0d want 0", word_idx_out); else pass_cnt++;
    chk_cnt++; if (paused_out !== 1'b0 || load_ready_out !== 1'b1) $display("FAIL mid_rst_ctl: got paused=%b ready=%b want 0/1", paused_out, load_ready_out); else pass_cnt++;
    tick;
    reset_n_in = 1'b1;
    repeat (20) tick;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL idle_next_idx: got %0d want 0", word_idx_out); else pass_cnt++;
    chk_cnt++; if (Word_out !== 32'h0) $display("FAIL idle_next_word: got %h want 0", Word_out); else pass_cnt++;
    load_valid_in = 1'b1;
    tick;
    load_valid_in = 1'b0;
    tick;
    chk_cnt++; if (Word_out !== exp_word(4'd0, 32'hDEADBEEF)) $display("FAIL reload_word: got %h want %h", Word_out, exp_word(4'd0, 32'hDEADBEEF)); else pass_cnt++;
    repeat (6) tick;
    chk_cnt++; if (word_idx_out !== 4'd0) $display("FAIL no_stale_next: got %0d want 0", word_idx_out); else pass_cnt++;
    btn_next_in = 1'b0;
  endtask

  initial begin
    test_reset;
    test_load_auto;
    test_hold_pause;
    test_next_bounce;
    test_hold_resume;
    test_simul_dwell_next;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
